// File: rtl/key_pkg.sv
// Shared definitions for the multi-key debouncer: channel FSM encoding and
// helpers that turn millisecond timings into cycle counts and counter widths.
// Pure declarations; no logic, no latency, no flow control.
package key_pkg;

  typedef enum logic [1:0] {
    KS_IDLE   = 2'd0,
    KS_HELD   = 2'd1,
    KS_REPEAT = 2'd2
  } key_state_e;

  // Cycles in 'ms' milliseconds of a clock running at 'freq' Hz.
  function automatic int ms_to_cycles(input int freq, input int ms);
    return (freq / 1000) * ms;
  endfunction

  // Bits needed for a counter that must be able to hold 'terminal'.
  function automatic int cnt_width(input int terminal);
    return $clog2(terminal + 1);
  endfunction

endpackage

// File: rtl/key_debounce_multi_if.sv
// Key pin bundle and conditioned event outputs of the multi-key debouncer.
// Carries combinational wires only; no latency of its own.
// No backpressure: events are single-cycle pulses the consumer must sample.
interface key_debounce_multi_if #(
  parameter int KEY_NUM = 4
);

  logic [KEY_NUM-1:0] I_key;
  logic [KEY_NUM-1:0] O_key_level;
  logic [KEY_NUM-1:0] O_press;
  logic [KEY_NUM-1:0] O_release;
  logic [KEY_NUM-1:0] O_long;
  logic [KEY_NUM-1:0] O_repeat;
  logic [KEY_NUM-1:0] O_toggle;

  // Side that owns the pins and consumes the events.
  modport master (
    output I_key,
    input  O_key_level, O_press, O_release, O_long, O_repeat, O_toggle
  );

  // The debouncer itself.
  modport slave (
    input  I_key,
    output O_key_level, O_press, O_release, O_long, O_repeat, O_toggle
  );

endinterface

// File: rtl/key_debounce_chan.sv
// One key channel: 2-FF synchroniser, debounce counter, press/long/repeat FSM.
// Latency: settled pin to level/press is 2+DB_CNT cycles; all outputs registered.
// No backpressure: events are one-cycle pulses, dropped if not sampled.
module key_debounce_chan
  import key_pkg::*;
#(
  parameter int DB_CNT     = 20,
  parameter int LONG_CNT   = 100,
  parameter int REP_CNT    = 50,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic I_clk,
  input  logic sys_resetn,
  input  logic key_in,
  output logic level,
  output logic press,
  output logic rel,
  output logic long_p,
  output logic rep,
  output logic toggle
);

  localparam int DB_W   = cnt_width(DB_CNT);
  localparam int HOLD_W = cnt_width((LONG_CNT > REP_CNT) ? LONG_CNT : REP_CNT);

  localparam logic [DB_W-1:0]   DB_TERM   = DB_W'(DB_CNT - 1);
  localparam logic [HOLD_W-1:0] LONG_TERM = HOLD_W'(LONG_CNT - 1);
  localparam logic [HOLD_W-1:0] REP_TERM  = HOLD_W'(REP_CNT - 1);

  // Raw pin level that means "not pressed"; synchroniser resets to it so a
  // key held through reset is re-detected with the full latency.
  localparam logic PIN_RELEASED = ACTIVE_LOW ? 1'b1 : 1'b0;

  logic sync1, sync2;
  logic key_n;
  logic differ;
  logic accept;

  logic [DB_W-1:0]   db, db_nxt;
  logic [HOLD_W-1:0] hold, hold_nxt;

  key_state_e state, state_nxt;
  logic press_nxt, rel_nxt, long_nxt, rep_nxt, toggle_nxt;

  // Two-stage synchroniser for the asynchronous pin.
  always_ff @(posedge I_clk or negedge sys_resetn) begin
    if (!sys_resetn) begin
      sync1 <= PIN_RELEASED;
      sync2 <= PIN_RELEASED;
    end else begin
      sync1 <= key_in;
      sync2 <= sync1;
    end
  end

  assign key_n = ACTIVE_LOW ? ~sync2 : sync2;

  // Debounce: count consecutive cycles the input disagrees with the level;
  // accepting the change on the terminal count also clears the counter.
  always_comb begin
    differ = (key_n != level);
    accept = differ && (db == DB_TERM);
    db_nxt = '0;
    if (differ && !accept) begin
      db_nxt = db + DB_W'(1);
    end
  end

  // Debounce counter and accepted level.
  always_ff @(posedge I_clk or negedge sys_resetn) begin
    if (!sys_resetn) begin
      db    <= '0;
      level <= 1'b0;
    end else begin
      db    <= db_nxt;
      level <= level ^ accept;
    end
  end

  // Channel FSM next state and event pulses; a release accepted in the same
  // cycle as a terminal hold count wins and suppresses the long/repeat pulse.
  always_comb begin
    state_nxt  = state;
    hold_nxt   = hold + HOLD_W'(1);
    press_nxt  = 1'b0;
    rel_nxt    = 1'b0;
    long_nxt   = 1'b0;
    rep_nxt    = 1'b0;
    toggle_nxt = toggle;
    case (state)
      KS_IDLE: begin
        hold_nxt = '0;
        if (accept && key_n) begin
          state_nxt  = KS_HELD;
          press_nxt  = 1'b1;
          toggle_nxt = ~toggle;
        end
      end
      KS_HELD: begin
        if (accept) begin
          state_nxt = KS_IDLE;
          rel_nxt   = 1'b1;
          hold_nxt  = '0;
        end else if (hold == LONG_TERM) begin
          state_nxt = KS_REPEAT;
          long_nxt  = 1'b1;
          hold_nxt  = '0;
        end
      end
      KS_REPEAT: begin
        if (accept) begin
          state_nxt = KS_IDLE;
          rel_nxt   = 1'b1;
          hold_nxt  = '0;
        end else if (hold == REP_TERM) begin
          rep_nxt  = 1'b1;
          hold_nxt = '0;
        end
      end
      default: begin
        state_nxt = KS_IDLE;
        hold_nxt  = '0;
      end
    endcase
  end

  // FSM state, hold counter and registered event outputs.
  always_ff @(posedge I_clk or negedge sys_resetn) begin
    if (!sys_resetn) begin
      state  <= KS_IDLE;
      hold   <= '0;
      press  <= 1'b0;
      rel    <= 1'b0;
      long_p <= 1'b0;
      rep    <= 1'b0;
      toggle <= 1'b0;
    end else begin
      state  <= state_nxt;
      hold   <= hold_nxt;
      press  <= press_nxt;
      rel    <= rel_nxt;
      long_p <= long_nxt;
      rep    <= rep_nxt;
      toggle <= toggle_nxt;
    end
  end

endmodule

// File: rtl/key_debounce_multi.sv
// Multi-key push-button conditioner: KEY_NUM independent debounce channels.
// Latency: 2+DB_CNT cycles pin to press/release; long/repeat timed from press.
// No backpressure: all events are registered one-cycle pulses.
module key_debounce_multi
  import key_pkg::*;
#(
  parameter int CLK_FREQ    = 27_000_000,
  parameter int KEY_NUM     = 4,
  parameter int DEBOUNCE_MS = 20,
  parameter int LONG_MS     = 500,
  parameter int REPEAT_MS   = 100,
  parameter int ACTIVE_LOW  = 1
) (
  input  logic                  I_clk,
  input  logic                  sys_resetn,
  key_debounce_multi_if.slave   bus
);

  localparam int DB_CNT   = ms_to_cycles(CLK_FREQ, DEBOUNCE_MS);
  localparam int LONG_CNT = ms_to_cycles(CLK_FREQ, LONG_MS);
  localparam int REP_CNT  = ms_to_cycles(CLK_FREQ, REPEAT_MS);

  // Counters compare against constant-1 terminals, so anything below 2
  // would leave no room to count.
  if (DB_CNT < 2) begin : g_bad_db
    $error("key_debounce_multi: debounce count must be at least 2 cycles");
  end
  if (LONG_CNT < 2) begin : g_bad_long
    $error("key_debounce_multi: long-press count must be at least 2 cycles");
  end
  if (REP_CNT < 2) begin : g_bad_rep
    $error("key_debounce_multi: repeat count must be at least 2 cycles");
  end
  if (KEY_NUM < 1 || KEY_NUM > 16) begin : g_bad_num
    $error("key_debounce_multi: KEY_NUM must be in 1..16");
  end

  wire [KEY_NUM-1:0] level_w;
  wire [KEY_NUM-1:0] press_w;
  wire [KEY_NUM-1:0] rel_w;
  wire [KEY_NUM-1:0] long_w;
  wire [KEY_NUM-1:0] rep_w;
  wire [KEY_NUM-1:0] toggle_w;

  for (genvar i = 0; i < KEY_NUM; i++) begin : g_chan
    key_debounce_chan #(
      .DB_CNT     (DB_CNT),
      .LONG_CNT   (LONG_CNT),
      .REP_CNT    (REP_CNT),
      .ACTIVE_LOW (ACTIVE_LOW != 0)
    ) u_chan (
      .I_clk      (I_clk),
      .sys_resetn (sys_resetn),
      .key_in     (bus.I_key[i]),
      .level      (level_w[i]),
      .press      (press_w[i]),
      .rel        (rel_w[i]),
      .long_p     (long_w[i]),
      .rep        (rep_w[i]),
      .toggle     (toggle_w[i])
    );
  end

  assign bus.O_key_level = level_w;
  assign bus.O_press     = press_w;
  assign bus.O_release   = rel_w;
  assign bus.O_long      = long_w;
  assign bus.O_repeat    = rep_w;
  assign bus.O_toggle    = toggle_w;

endmodule

// File: tb/tb_key_debounce_multi.sv
// Directed bench for key_debounce_multi with DB_CNT=20, LONG_CNT=100, REP_CNT=50.
// Inputs change 1 time unit after a rising edge; outputs sampled at the same point.
// Cycle numbers below count rising edges after the input change.
module tb_key_debounce_multi;

  logic I_clk;
  logic sys_resetn;
  int   checks;
  int   errors;
  int   npress;

  key_debounce_multi_if #(.KEY_NUM(4)) kif ();

  key_debounce_multi #(
    .CLK_FREQ    (10_000),
    .KEY_NUM     (4),
    .DEBOUNCE_MS (2),
    .LONG_MS     (10),
    .REPEAT_MS   (5),
    .ACTIVE_LOW  (1)
  ) dut (
    .I_clk      (I_clk),
    .sys_resetn (sys_resetn),
    .bus        (kif)
  );

  initial I_clk = 1'b0;
  always #5 I_clk = ~I_clk;

  task automatic tick(input int n);
    repeat (n) @(posedge I_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    npress     = 0;
    sys_resetn = 1'b0;
    kif.I_key  = 4'hF;

    // Reset state
    #2;
    chk("rst_level",  kif.O_key_level, 4'h0);
    chk("rst_press",  kif.O_press,     4'h0);
    chk("rst_toggle", kif.O_toggle,    4'h0);
    repeat (3) @(posedge I_clk);
    #1 sys_resetn = 1'b1;
    tick(5);
    chk("idle_events", {kif.O_press, kif.O_release, kif.O_long, kif.O_repeat}, 16'h0);

    // Clean press on key 0, held 60 cycles
    kif.I_key[0] = 1'b0;
    tick(21);
    chk("clean_press_c21", kif.O_press, 4'h0);
    tick(1);
    chk("clean_press_c22", kif.O_press,     4'b0001);
    chk("clean_level",     kif.O_key_level, 4'b0001);
    chk("clean_toggle",    kif.O_toggle,    4'b0001);
    tick(1);
    chk("clean_press_1cyc", kif.O_press, 4'h0);
    tick(37);
    chk("clean_no_long", kif.O_long, 4'h0);
    kif.I_key[0] = 1'b1;
    tick(21);
    chk("clean_rel_c21", kif.O_release, 4'h0);
    tick(1);
    chk("clean_rel_c22",      kif.O_release,   4'b0001);
    chk("clean_rel_level",    kif.O_key_level, 4'b0000);
    chk("clean_rel_toggle",   kif.O_toggle,    4'b0001);
    tick(5);

    // Bounce on key 1: toggles every 5 cycles, then settles pressed
    for (int k = 0; k < 20; k++) begin
      kif.I_key[1] = k[0];
      for (int j = 0; j < 5; j++) begin
        tick(1);
        npress += int'(kif.O_press[1]);
      end
    end
    kif.I_key[1] = 1'b0;
    for (int j = 0; j < 21; j++) begin
      tick(1);
      npress += int'(kif.O_press[1]);
    end
    chk("bounce_c21", kif.O_press, 4'h0);
    tick(1);
    npress += int'(kif.O_press[1]);
    chk("bounce_c22", kif.O_press, 4'b0010);
    tick(1);
    chk("bounce_single_press", npress, 1);
    kif.I_key[1] = 1'b1;
    tick(30);
    chk("bounce_released", kif.O_key_level, 4'h0);

    // Long hold on key 2
    kif.I_key[2] = 1'b0;
    tick(22);
    chk("long_press", kif.O_press, 4'b0100);
    tick(99);
    chk("long_c99", kif.O_long, 4'h0);
    tick(1);
    chk("long_c100", kif.O_long, 4'b0100);
    tick(49);
    chk("rep_c149", kif.O_repeat, 4'h0);
    tick(1);
    chk("rep_c150", kif.O_repeat, 4'b0100);
    tick(1);
    chk("rep_1cyc", kif.O_repeat, 4'h0);
    tick(49);
    chk("rep_c200", kif.O_repeat, 4'b0100);
    tick(50);
    chk("rep_c250", kif.O_repeat, 4'b0100);
    tick(10);
    kif.I_key[2] = 1'b1;
    tick(21);
    chk("long_rel_c21", kif.O_release, 4'h0);
    tick(1);
    chk("long_rel_c22", kif.O_release, 4'b0100);
    tick(5);

    // Release accepted in the hold==99 cycle: release wins over long
    kif.I_key[2] = 1'b0;
    tick(22);
    chk("coll_press", kif.O_press, 4'b0100);
    tick(78);
    kif.I_key[2] = 1'b1;
    tick(21);
    chk("coll_c99_quiet", {kif.O_long, kif.O_release}, 8'h0);
    tick(1);
    chk("coll_release", kif.O_release, 4'b0100);
    chk("coll_no_long", kif.O_long,    4'h0);
    tick(1);
    chk("coll_no_long_after", kif.O_long, 4'h0);
    chk("coll_level",         kif.O_key_level, 4'h0);
    tick(5);

    // Simultaneous press on keys 0 and 3
    kif.I_key = 4'b0110;
    tick(21);
    chk("simul_c21", kif.O_press, 4'h0);
    tick(1);
    chk("simul_press",  kif.O_press,  4'b1001);
    chk("simul_toggle", kif.O_toggle, 4'b1010);
    tick(100);
    chk("simul_long", kif.O_long, 4'b1001);
    tick(10);
    chk("simul_held", kif.O_key_level, 4'b1001);

    // Reset while keys 0 and 3 sit in REPEAT
    sys_resetn = 1'b0;
    #1;
    chk("mid_rst_level",  kif.O_key_level, 4'h0);
    chk("mid_rst_toggle", kif.O_toggle,    4'h0);
    repeat (3) @(posedge I_clk);
    #1 sys_resetn = 1'b1;
    tick(21);
    chk("post_rst_c21", kif.O_press, 4'h0);
    tick(1);
    chk("post_rst_press",  kif.O_press,  4'b1001);
    chk("post_rst_toggle", kif.O_toggle, 4'b1001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
